full_hk_rx: RTL and testbench



---
 rtl/full_hk_pkg.sv | 9 +
 rtl/full_hk_rx_if.sv | 22 ++
 rtl/full_hk_sync.sv | 24 ++
 rtl/full_hk_rx.sv | 114 +++++++++++
 tb/tb_full_hk_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/full_hk_pkg.sv
// Shared types and limits for the four-phase handshake receiver.
// State encoding plus the minimum synchroniser depth the receiver accepts.
package full_hk_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, ACK} full_hk_state_t;

    localparam int FULL_HK_SYNC_MIN = 2;

endpackage

// File: rtl/full_hk_rx_if.sv
// Four-phase request/ack pair from the write domain plus the local valid/ready consumer port.
// master = write-domain sender and consumer side; slave = the receiver.
interface full_hk_rx_if #(
    parameter int DW = 8
);
    logic          wr_vld;
    logic [DW-1:0] wr_data;
    logic          rd_ack;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_rdy;

    modport master (
        output wr_vld, wr_data, out_rdy,
        input  rd_ack, out_vld, out_data
    );

    modport slave (
        input  wr_vld, wr_data, out_rdy,
        output rd_ack, out_vld, out_data
    );
endinterface

// File: rtl/full_hk_sync.sv
// Multi-flop level synchroniser for a single asynchronous bit, reset to 0.
// Latency STAGES edges; no backpressure.
module full_hk_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/full_hk_rx.sv
// Four-phase handshake receiver: syncs wr_vld, captures wr_data, hands it to a valid/ready consumer, then acks.
// out_vld rises SYNC_STAGES+1 edges after wr_vld; a stalled consumer holds the word and withholds rd_ack. Timeout: FULL_HK_TIMEOUT_EN.
module full_hk_rx
    import full_hk_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    full_hk_rx_if.slave      hk,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             hk_err
);

    if (SYNC_STAGES < FULL_HK_SYNC_MIN) begin : g_bad_sync
        $error("full_hk_rx: SYNC_STAGES must be at least %0d", FULL_HK_SYNC_MIN);
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("full_hk_rx: TIMEOUT_CYC must be at least 1");
    end

    full_hk_state_t state, state_nxt;
    logic           wr_vld_s;
    logic           rd_ack_q, rd_ack_nxt;
    logic           out_vld_q, out_vld_nxt;
    logic [DW-1:0]  out_data_q;
    logic           capture;
    logic           done;

    full_hk_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (hk.wr_vld),
        .q   (wr_vld_s)
    );

    // rd_ack and out_vld come straight off their own flops so the ack seen
    // by the write domain never glitches on a state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ack_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            xfer_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            rd_ack_q  <= rd_ack_nxt;
            out_vld_q <= out_vld_nxt;
            if (capture) begin
                out_data_q <= hk.wr_data;
            end
            if (done) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (wr_vld_s)                 state_nxt = HOLD;
            HOLD:    if (out_vld_q && hk.out_rdy)  state_nxt = ACK;
            ACK:     if (!wr_vld_s)                state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_ack_nxt  = 1'b0;
        out_vld_nxt = 1'b0;
        capture     = 1'b0;
        done        = 1'b0;
        rd_ack_nxt  = (state_nxt == ACK);
        out_vld_nxt = (state_nxt == HOLD);
        capture     = (state == IDLE) && wr_vld_s;
        done        = (state == ACK) && !wr_vld_s;
    end

    assign hk.rd_ack   = rd_ack_q;
    assign hk.out_vld  = out_vld_q;
    assign hk.out_data = out_data_q;

`ifdef FULL_HK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          hk_err_q;

    // Saturating ACK-phase timer; the error is only reported, the FSM keeps waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt   <= '0;
            hk_err_q <= 1'b0;
        end else if (state != ACK) begin
            to_cnt <= '0;
        end else begin
            if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                hk_err_q <= 1'b1;
            end
        end
    end

    assign hk_err = hk_err_q;
`else
    assign hk_err = 1'b0;
`endif

endmodule

// File: tb/tb_full_hk_rx.sv
// Scoreboard bench for full_hk_rx: a four-phase sender model and a consumer monitor, SYNC_STAGES 2 and 4.
module tb_full_hk_rx;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    full_hk_rx_if #(.DW(DW)) if2 ();
    full_hk_rx_if #(.DW(DW)) if4 ();

    logic [1:0]    wv;
    logic [1:0]    ordy;
    logic [DW-1:0] wd [2];
    logic [1:0]    ack;
    logic [1:0]    ov;
    logic [DW-1:0] od [2];
    logic [CW-1:0] cnt2, cnt4;
    logic          err2, err4;

    assign if2.wr_vld  = wv[0];
    assign if2.wr_data = wd[0];
    assign if2.out_rdy = ordy[0];
    assign ack[0]      = if2.rd_ack;
    assign ov[0]       = if2.out_vld;
    assign od[0]       = if2.out_data;

    assign if4.wr_vld  = wv[1];
    assign if4.wr_data = wd[1];
    assign if4.out_rdy = ordy[1];
    assign ack[1]      = if4.rd_ack;
    assign ov[1]       = if4.out_vld;
    assign od[1]       = if4.out_data;

    full_hk_rx #(.DW(DW), .SYNC_STAGES(2), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut2 (
        .clk(clk), .rst(rst), .hk(if2.slave), .xfer_cnt(cnt2), .hk_err(err2));

    full_hk_rx #(.DW(DW), .SYNC_STAGES(4), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut4 (
        .clk(clk), .rst(rst), .hk(if4.slave), .xfer_cnt(cnt4), .hk_err(err4));

`ifdef FULL_HK_TIMEOUT_EN
    localparam logic TO_ERR = 1'b1;
`else
    localparam logic TO_ERR = 1'b0;
`endif

    logic [DW-1:0] exp_q [$];
    int  total     = 0;
    int  bad       = 0;
    int  beats     = 0;
    int  exp_beats = 0;
    int  exp_cnt [2];
    bit  mon_en    = 1'b0;
    bit  rdy_rand  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor for dut2: every accepting beat must deliver the oldest outstanding word.
    always @(negedge clk) begin
        if (!rst && mon_en && ov[0] && ordy[0]) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat: unexpected word %0h, none required", od[0]);
            end else begin
                automatic logic [DW-1:0] e = exp_q.pop_front();
                if (od[0] !== e) begin
                    bad++;
                    $display("FAIL beat: got %0h, required %0h", od[0], e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_rand) ordy[0] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_ack(input int d, input logic v, input string name);
        int n = 0;
        while (ack[d] !== v && n < 300) begin
            step();
            n++;
        end
        check(name, 32'(ack[d]), 32'(v));
    endtask

    task automatic wait_ov(input int d, input string name);
        int n = 0;
        while (ov[d] !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check(name, 32'(ov[d]), 32'd1);
    endtask

    function automatic void expect_word(input logic [DW-1:0] w);
        exp_q.push_back(w);
        exp_beats++;
    endfunction

    // Sender model: raise request, hold data until ack, drop request, wait for ack low.
    task automatic send(input logic [DW-1:0] data);
        expect_word(data);
        wv[0] = 1'b1;
        wd[0] = data;
        wait_ack(0, 1'b1, "send ack rise");
        wv[0] = 1'b0;
        wd[0] = DW'($urandom);
        wait_ack(0, 1'b0, "send ack fall");
        exp_cnt[0]++;
    endtask

    task automatic lat_test(input int d, input int s, input logic [DW-1:0] data);
        ordy[d] = 1'b1;
        if (d == 0) expect_word(data);
        wv[d] = 1'b1;
        wd[d] = data;
        for (int e = 1; e <= s + 1; e++) begin
            step();
            if (e <= s) check($sformatf("lat%0d out_vld early e%0d", s, e), 32'(ov[d]), 32'd0);
        end
        check($sformatf("lat%0d out_vld", s), 32'(ov[d]), 32'd1);
        check($sformatf("lat%0d out_data", s), 32'(od[d]), 32'(data));
        step();
        check($sformatf("lat%0d ack rise", s), 32'(ack[d]), 32'd1);
        wv[d] = 1'b0;
        wd[d] = DW'($urandom);
        for (int e = 1; e <= s + 1; e++) begin
            step();
            if (e <= s) check($sformatf("lat%0d ack held e%0d", s, e), 32'(ack[d]), 32'd1);
        end
        check($sformatf("lat%0d ack fall", s), 32'(ack[d]), 32'd0);
        exp_cnt[d]++;
        check($sformatf("lat%0d xfer_cnt", s), 32'(d == 0 ? cnt2 : cnt4), 32'(exp_cnt[d]));
    endtask

    initial begin
        wv         = '0;
        ordy       = '0;
        wd[0]      = '0;
        wd[1]      = '0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        rst        = 1'b1;
        repeat (3) step();
        check("reset rd_ack", 32'(ack), 32'd0);
        check("reset out_vld", 32'(ov), 32'd0);
        check("reset out_data", 32'(od[0]), 32'd0);
        check("reset xfer_cnt", 32'(cnt2), 32'd0);
        check("reset hk_err", 32'({err4, err2}), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        lat_test(0, 2, 8'hA5);

        // Consumer stall
        ordy[0] = 1'b0;
        expect_word(8'h77);
        wv[0] = 1'b1;
        wd[0] = 8'h77;
        wait_ov(0, "stall out_vld");
        for (int i = 0; i < 20; i++) begin
            step();
            check("stall out_vld", 32'(ov[0]), 32'd1);
            check("stall out_data", 32'(od[0]), 32'h77);
            check("stall rd_ack", 32'(ack[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        step();
        check("stall release ack", 32'(ack[0]), 32'd1);
        wv[0] = 1'b0;
        wait_ack(0, 1'b0, "stall ack fall");
        exp_cnt[0]++;

        for (int i = 1; i <= 5; i++) send(DW'(i));
        check("b2b beats", 32'(beats), 32'(exp_beats));
        check("b2b xfer_cnt", 32'(cnt2), 32'(exp_cnt[0]));

        rdy_rand = 1'b1;
        for (int i = 0; i < 30; i++) send(DW'($urandom));
        rdy_rand = 1'b0;
        ordy[0]  = 1'b1;
        step();
        check("rand beats", 32'(beats), 32'(exp_beats));
        check("rand queue empty", 32'(exp_q.size()), 32'd0);
        check("rand xfer_cnt", 32'(cnt2), 32'(exp_cnt[0]));

        // Request left high in ACK
        expect_word(8'hE1);
        wv[0] = 1'b1;
        wd[0] = 8'hE1;
        wait_ack(0, 1'b1, "timeout ack rise");
        repeat (20) step();
        check("timeout hk_err", 32'(err2), 32'(TO_ERR));
        check("timeout ack held", 32'(ack[0]), 32'd1);
        wv[0] = 1'b0;
        wait_ack(0, 1'b0, "timeout ack fall");
        exp_cnt[0]++;
        step();
        check("timeout hk_err sticky", 32'(err2), 32'(TO_ERR));
        check("timeout xfer_cnt", 32'(cnt2), 32'(exp_cnt[0]));
        check("timeout beats", 32'(beats), 32'(exp_beats));

        // Reset in HOLD with the request still high
        mon_en  = 1'b0;
        ordy[0] = 1'b0;
        wv[0]   = 1'b1;
        wd[0]   = 8'h3C;
        wait_ov(0, "rst-hold out_vld");
        rst = 1'b1;
        step();
        check("rst-hold out_vld", 32'(ov[0]), 32'd0);
        check("rst-hold rd_ack", 32'(ack[0]), 32'd0);
        check("rst-hold out_data", 32'(od[0]), 32'd0);
        check("rst-hold xfer_cnt", 32'(cnt2), 32'd0);
        check("rst-hold hk_err", 32'(err2), 32'd0);
        rst = 1'b0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (e < 3) check("rst-hold recapture early", 32'(ov[0]), 32'd0);
        end
        check("rst-hold recapture", 32'(ov[0]), 32'd1);
        check("rst-hold recapture data", 32'(od[0]), 32'h3C);

        // Reset in ACK with the request still high
        ordy[0] = 1'b1;
        step();
        check("rst-ack in ACK", 32'(ack[0]), 32'd1);
        rst = 1'b1;
        step();
        check("rst-ack rd_ack", 32'(ack[0]), 32'd0);
        check("rst-ack out_vld", 32'(ov[0]), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            if (e < 3) check("rst-ack recapture early", 32'(ov[0]), 32'd0);
        end
        check("rst-ack recapture", 32'(ov[0]), 32'd1);
        check("rst-ack recapture data", 32'(od[0]), 32'h3C);
        step();
        check("rst-ack ack again", 32'(ack[0]), 32'd1);
        wv[0] = 1'b0;
        wait_ack(0, 1'b0, "rst-ack ack fall");
        exp_cnt[0]++;
        check("rst-ack xfer_cnt", 32'(cnt2), 32'(exp_cnt[0]));

        lat_test(1, 4, 8'h5A);
        check("sync4 hk_err", 32'(err4), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
